// File: rtl/xor_unit_arbiter_pkg.sv
// Shared constants and FSM encoding for the round-robin XOR unit arbiter.
package xor_unit_arbiter_pkg;

   localparam int unsigned NREQ_DEF = 4;
   localparam int unsigned IDW_DEF  = 2;
   localparam int unsigned CNTW_DEF = 16;
   localparam int unsigned DW       = 8;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

endpackage

// File: rtl/xor_unit_arbiter_rr_arbiter.sv
// Round-robin grant: first valid requester at or after ptr, wrapping modulo NREQ.
module rr_arbiter
   import xor_unit_arbiter_pkg::*;
#(
   parameter int unsigned NREQ = NREQ_DEF,
   parameter int unsigned IDW  = IDW_DEF
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  idx
);

   logic           found;
   logic [IDW-1:0] sel;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      sel   = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         sel = IDW'((32'(ptr) + k) % NREQ);
         if (!found && req[sel]) begin
            found      = 1'b1;
            grant[sel] = 1'b1;
            idx        = sel;
         end
      end
   end

endmodule

// File: rtl/xor_unit_arbiter_xorer.sv
// Shared XOR datapath: purely combinational A ^ B.
module xorer
   import xor_unit_arbiter_pkg::*;
#(
   parameter int unsigned W = DW
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y
);

   assign y = a ^ b;

endmodule

// File: rtl/xor_unit_arbiter.sv
// Shares one XOR unit among NREQ requesters with round-robin arbitration and
// a single registered result stage tagged with the winning requester's ID.
module xor_unit_arbiter
   import xor_unit_arbiter_pkg::*;
#(
   parameter int unsigned NREQ = NREQ_DEF,
   parameter int unsigned IDW  = IDW_DEF,
   parameter int unsigned CNTW = CNTW_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [DW*NREQ-1:0] req_a,
   input  logic [DW*NREQ-1:0] req_b,
   output logic [NREQ-1:0]    req_ready,
   output logic               rsp_valid,
   output logic [DW-1:0]      rsp_data,
   output logic [IDW-1:0]     rsp_id,
   input  logic               rsp_ready,
   output logic               busy,
   output logic [CNTW-1:0]    op_count
);

   state_t          state;
   logic [IDW-1:0]  ptr;
   logic [NREQ-1:0] grant;
   logic [IDW-1:0]  gnt_idx;
   logic            accept;
   logic            rsp_xfer;
   logic [DW-1:0]   a_sel;
   logic [DW-1:0]   b_sel;
   logic [DW-1:0]   xor_out;

   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (grant),
      .idx   (gnt_idx)
   );

   // One-hot AND-OR operand mux driven by the grant vector.
   always_comb begin
      a_sel = '0;
      b_sel = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (grant[k]) begin
            a_sel = req_a[DW*k +: DW];
            b_sel = req_b[DW*k +: DW];
         end
      end
   end

   xorer #(
      .W (DW)
   ) u_xorer (
      .a (a_sel),
      .b (b_sel),
      .y (xor_out)
   );

   // Accept may coincide with a drain, sustaining one op per cycle.
   assign accept    = (|req_valid) && (!rsp_valid || rsp_ready);
   assign req_ready = grant & {NREQ{accept & rst_n}};
   assign rsp_valid = (state == FULL);
   assign busy      = rsp_valid;
   assign rsp_xfer  = rsp_valid && rsp_ready;

   // Result stage FSM, result register and rotation pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= EMPTY;
         rsp_data <= '0;
         rsp_id   <= '0;
         ptr      <= '0;
      end else begin
         if (accept) begin
            rsp_data <= xor_out;
            rsp_id   <= gnt_idx;
            ptr      <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
         end
         case (state)
            EMPTY:   if (accept) state <= FULL;
            FULL:    if (rsp_ready && !accept) state <= EMPTY;
            default: state <= EMPTY;
         endcase
      end
   end

   // Saturating count of completed responses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_count <= '0;
      end else if (rsp_xfer && (op_count != '1)) begin
         op_count <= op_count + CNTW'(1);
      end
   end

endmodule

// File: tb/tb_xor_unit_arbiter.sv
// Scoreboard bench for xor_unit_arbiter: a cycle model predicts grants, and
// expected results are queued on accept and compared when the DUT presents them.
module tb_xor_unit_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [3:0]  req_ready;
   logic        rsp_valid;
   logic [7:0]  rsp_data;
   logic [1:0]  rsp_id;
   logic        rsp_ready;
   logic        busy;
   logic [15:0] op_count;

   xor_unit_arbiter #(
      .NREQ (4),
      .IDW  (2),
      .CNTW (16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .rsp_ready (rsp_ready),
      .busy      (busy),
      .op_count  (op_count)
   );

   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model state
   logic        m_full;
   logic [1:0]  m_ptr;
   logic [15:0] m_cnt;
   logic [3:0]  pend;
   logic [9:0]  sb[$];

   always @(negedge clk) begin
      logic       acc;
      logic       found;
      int         gi;
      logic [3:0] eg;
      if (!rst_n) begin
         m_full = 1'b0;
         m_ptr  = 2'd0;
         m_cnt  = 16'd0;
         pend   = 4'd0;
         sb.delete();
      end else begin
         if (pend != 4'd0) check("hold_valid", 32'(req_valid & pend), 32'(pend));
         acc   = (|req_valid) && (!m_full || rsp_ready);
         found = 1'b0;
         gi    = 0;
         for (int k = 0; k < 4; k++) begin
            int j;
            j = (int'(m_ptr) + k) % 4;
            if (!found && req_valid[j]) begin
               found = 1'b1;
               gi    = j;
            end
         end
         eg = acc ? 4'(1 << gi) : 4'd0;
         check("req_ready", 32'(req_ready), 32'(eg));
         check("rsp_valid", 32'(rsp_valid), 32'(m_full));
         check("busy", 32'(busy), 32'(m_full));
         check("op_count", 32'(op_count), 32'(m_cnt));
         if (m_full) begin
            if (sb.size() == 0) begin
               check("sb_depth", 32'(sb.size()), 32'd1);
            end else begin
               check("rsp_data", 32'(rsp_data), 32'(sb[0][7:0]));
               check("rsp_id", 32'(rsp_id), 32'(sb[0][9:8]));
            end
            if (rsp_ready) begin
               if (sb.size() > 0) void'(sb.pop_front());
               if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
         end
         if (acc) begin
            sb.push_back({2'(gi), req_a[8*gi +: 8] ^ req_b[8*gi +: 8]});
            m_ptr = 2'((gi + 1) % 4);
         end
         m_full = acc ? 1'b1 : (rsp_ready ? 1'b0 : m_full);
         pend   = req_valid & ~eg;
      end
   end

   // New operands only on ports without an outstanding request.
   task automatic drive(input logic [3:0] v, input logic rr);
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         if (!pend[i]) begin
            req_a[8*i +: 8] = 8'($urandom);
            req_b[8*i +: 8] = 8'($urandom);
         end
      end
      req_valid = v;
      rsp_ready = rr;
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] held;
      rst_n     = 1'b0;
      req_valid = 4'd0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_op_count", 32'(op_count), 32'd0);
      #2 rst_n = 1'b1;

      // Reset mid-run with a result held; ptr left at 2 beforehand
      drive(4'b0010, 1'b0);
      drive(4'b1111, 1'b0);
      @(negedge clk);
      check("pre_rst_valid", 32'(rsp_valid), 32'd1);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("rst_mid_valid", 32'(rsp_valid), 32'd0);
      check("rst_mid_data", 32'(rsp_data), 32'd0);
      check("rst_mid_id", 32'(rsp_id), 32'd0);
      check("rst_mid_cnt", 32'(op_count), 32'd0);
      check("rst_mid_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_gnt", 32'(req_ready), 32'b0001);
      drive(4'b1110, 1'b1);
      drive(4'b1100, 1'b1);
      drive(4'b1000, 1'b1);
      drive(4'b0000, 1'b1);

      // Single op on requester 2
      drive(4'b0100, 1'b1);
      req_a[23:16] = 8'hA5;
      req_b[23:16] = 8'h0F;
      @(negedge clk);
      check("single_ready", 32'(req_ready), 32'b0100);
      drive(4'b0000, 1'b1);
      @(negedge clk);
      check("single_valid", 32'(rsp_valid), 32'd1);
      check("single_data", 32'(rsp_data), 32'hAA);
      check("single_id", 32'(rsp_id), 32'd2);

      // Round-robin from ptr 0 (accept req 3 alone first)
      drive(4'b1000, 1'b1);
      for (int k = 0; k < 5; k++) begin
         drive(4'b1111, 1'b1);
         @(negedge clk);
         check("rr_gnt", 32'(req_ready), 32'(1 << (k % 4)));
         if (k > 0) check("rr_id", 32'(rsp_id), 32'((k - 1) % 4));
      end
      drive(4'b1110, 1'b1);
      @(negedge clk);
      check("rr_id_last", 32'(rsp_id), 32'd0);
      drive(4'b1100, 1'b1);
      drive(4'b1000, 1'b1);
      drive(4'b0000, 1'b1);

      // Backpressure: result held 3 cycles, then drain plus accept together
      drive(4'b0001, 1'b1);
      held = req_a[7:0] ^ req_b[7:0];
      for (int k = 0; k < 3; k++) begin
         drive(4'b0100, 1'b0);
         @(negedge clk);
         check("bp_ready", 32'(req_ready), 32'd0);
         check("bp_data", 32'(rsp_data), 32'(held));
      end
      drive(4'b0100, 1'b1);
      @(negedge clk);
      check("bp_drain_acc", 32'(req_ready), 32'b0100);
      drive(4'b0000, 1'b1);
      @(negedge clk);
      check("bp_new_id", 32'(rsp_id), 32'd2);

      // Fairness: req 3 arriving after a req 0 grant wins next
      drive(4'b0001, 1'b1);
      @(negedge clk);
      check("fair_0", 32'(req_ready), 32'b0001);
      drive(4'b1001, 1'b1);
      @(negedge clk);
      check("fair_3", 32'(req_ready), 32'b1000);
      drive(4'b0001, 1'b1);
      @(negedge clk);
      check("fair_0b", 32'(req_ready), 32'b0001);
      drive(4'b0000, 1'b1);

      // Counter saturation
      for (int c = 0; c < 70000 && m_cnt != 16'hFFFF; c++) drive(4'b0001, 1'b1);
      drive(4'b0000, 1'b1);
      drive(4'b0000, 1'b1);
      @(negedge clk);
      check("cnt_sat", 32'(op_count), 32'hFFFF);
      drive(4'b0010, 1'b1);
      drive(4'b0000, 1'b1);
      drive(4'b0000, 1'b1);
      @(negedge clk);
      check("cnt_stick", 32'(op_count), 32'hFFFF);
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
